// File: rtl/perf_pkg.sv
// Shared definitions for the performance counter bank: FSM state encoding
// and the event channel assignments used by the processor top level.
package perf_pkg;

  typedef enum logic {
    RUN    = 1'b0,
    FROZEN = 1'b1
  } perf_state_e;

  localparam int unsigned EV_INST  = 0;
  localparam int unsigned EV_DHIT  = 1;
  localparam int unsigned EV_IHIT  = 2;
  localparam int unsigned EV_DREQ  = 3;
  localparam int unsigned EV_IREQ  = 4;
  localparam int unsigned EV_STALL = 5;

endpackage

// File: rtl/perf_counter_cell.sv
// Single performance counter: increment, synchronous clear, sticky overflow
// flag and a snapshot register that captures the post-increment value.
module perf_counter_cell
  import perf_pkg::*;
#(
  parameter int CNT_WIDTH = 32,
  parameter bit SATURATE  = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inc,
  input  logic                 clr,
  input  logic                 capture,
  output logic [CNT_WIDTH-1:0] cnt,
  output logic [CNT_WIDTH-1:0] snap,
  output logic                 ovf
);

  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] snap_q, snap_d;
  logic                 ovf_q, ovf_d;
  logic [CNT_WIDTH:0]   sum;

  // Next-state: clear beats increment; carry-out only sets the sticky flag.
  always_comb begin
    sum    = {1'b0, cnt_q} + {{CNT_WIDTH{1'b0}}, 1'b1};
    cnt_d  = cnt_q;
    ovf_d  = ovf_q;
    snap_d = snap_q;
    if (clr) begin
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (inc) begin
      if (sum[CNT_WIDTH]) begin
        ovf_d = 1'b1;
        cnt_d = SATURATE ? {CNT_WIDTH{1'b1}} : sum[CNT_WIDTH-1:0];
      end else begin
        cnt_d = sum[CNT_WIDTH-1:0];
      end
    end
    // Snapshot takes the value being written this edge, so the halt-cycle
    // increment is included.
    if (capture && !clr) begin
      snap_d = cnt_d;
    end
  end

  // Counter, overflow and snapshot registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= '0;
      snap_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      snap_q <= snap_d;
      ovf_q  <= ovf_d;
    end
  end

  assign cnt  = cnt_q;
  assign snap = snap_q;
  assign ovf  = ovf_q;

endmodule

// File: rtl/perf_counter_bank.sv
// Event counter bank: NUM_EVENTS event counters plus a cycle counter, a
// RUN/FROZEN FSM driven by halt/clear, and a registered read port.
module perf_counter_bank
  import perf_pkg::*;
#(
  parameter int NUM_EVENTS = 8,
  parameter int CNT_WIDTH  = 32,
  parameter bit SATURATE   = 1'b0,
  parameter int IDX_W      = $clog2(NUM_EVENTS + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [NUM_EVENTS-1:0] event_vec,
  input  logic                  halt,
  input  logic                  clear,
  input  logic                  rd_req,
  input  logic [IDX_W-1:0]      rd_idx,
  input  logic                  rd_snap,
  output logic                  rd_valid,
  output logic [CNT_WIDTH-1:0]  rd_data,
  output logic                  rd_err,
  output logic [NUM_EVENTS:0]   ovf,
  output logic                  frozen
);

  localparam int NCNT = NUM_EVENTS + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_EVENTS);

  perf_state_e state_q, state_d;

  logic [CNT_WIDTH-1:0] live_cnt [NCNT];
  logic [CNT_WIDTH-1:0] snap_cnt [NCNT];
  logic [NCNT-1:0]      inc_vec;
  logic [NCNT-1:0]      ovf_vec;
  logic                 capture;

  logic                 rd_valid_q, rd_valid_d;
  logic [CNT_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                 rd_err_q, rd_err_d;

  // FSM next state and counter controls; clear overrides a coincident halt.
  always_comb begin
    state_d = state_q;
    inc_vec = '0;
    capture = 1'b0;
    if (state_q == RUN && enable) begin
      inc_vec = {1'b1, event_vec};
    end
    if (clear) begin
      state_d = RUN;
    end else if (state_q == RUN && halt) begin
      state_d = FROZEN;
      capture = 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Top entry (index NUM_EVENTS) is the cycle counter.
  for (genvar g = 0; g < NCNT; g++) begin : g_cell
    perf_counter_cell #(
      .CNT_WIDTH (CNT_WIDTH),
      .SATURATE  (SATURATE)
    ) u_cell (
      .clk     (clk),
      .rst     (rst),
      .inc     (inc_vec[g]),
      .clr     (clear),
      .capture (capture),
      .cnt     (live_cnt[g]),
      .snap    (snap_cnt[g]),
      .ovf     (ovf_vec[g])
    );
  end

  // Read mux: samples pre-update counter values; data/err hold when idle.
  always_comb begin
    rd_valid_d = rd_req;
    rd_data_d  = rd_data_q;
    rd_err_d   = rd_err_q;
    if (rd_req) begin
      if (rd_idx > LAST_IDX) begin
        rd_data_d = '0;
        rd_err_d  = 1'b1;
      end else begin
        rd_data_d = rd_snap ? snap_cnt[rd_idx] : live_cnt[rd_idx];
        rd_err_d  = 1'b0;
      end
    end
  end

  // Response registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      rd_err_q   <= 1'b0;
    end else begin
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      rd_err_q   <= rd_err_d;
    end
  end

  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
  assign rd_err   = rd_err_q;
  assign ovf      = ovf_vec;
  assign frozen   = (state_q == FROZEN);

endmodule

// File: tb/tb_perf_counter_bank.sv
// Scoreboard bench: two banks (wrapping and saturating) share stimulus; each
// read pushes expected responses, per-bank monitors pop on rd_valid.
module tb_perf_counter_bank;
  import perf_pkg::*;

  localparam int NE = 4;
  localparam int CW = 8;
  localparam int IW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          enable = 1'b0;
  logic          halt = 1'b0;
  logic          clear = 1'b0;
  logic          rd_req = 1'b0;
  logic          rd_snap = 1'b0;
  logic [NE-1:0] event_vec = '0;
  logic [IW-1:0] rd_idx = '0;

  logic          rd_valid0, rd_err0, frozen0;
  logic [CW-1:0] rd_data0;
  logic [NE:0]   ovf0;
  logic          rd_valid1, rd_err1, frozen1;
  logic [CW-1:0] rd_data1;
  logic [NE:0]   ovf1;

  perf_counter_bank #(
    .NUM_EVENTS (NE),
    .CNT_WIDTH  (CW),
    .SATURATE   (1'b0)
  ) dut_wrap (
    .clk (clk), .rst (rst), .enable (enable), .event_vec (event_vec),
    .halt (halt), .clear (clear), .rd_req (rd_req), .rd_idx (rd_idx),
    .rd_snap (rd_snap), .rd_valid (rd_valid0), .rd_data (rd_data0),
    .rd_err (rd_err0), .ovf (ovf0), .frozen (frozen0)
  );

  perf_counter_bank #(
    .NUM_EVENTS (NE),
    .CNT_WIDTH  (CW),
    .SATURATE   (1'b1)
  ) dut_sat (
    .clk (clk), .rst (rst), .enable (enable), .event_vec (event_vec),
    .halt (halt), .clear (clear), .rd_req (rd_req), .rd_idx (rd_idx),
    .rd_snap (rd_snap), .rd_valid (rd_valid1), .rd_data (rd_data1),
    .rd_err (rd_err1), .ovf (ovf1), .frozen (frozen1)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [CW-1:0] data;
    logic          err;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endfunction

  // Wrapping bank response monitor.
  always @(negedge clk) begin
    if (rd_valid0 === 1'b1) begin
      if (q0.size() == 0) begin
        n_total++;
        $display("FAIL wrap_unexpected_rsp: got rd_valid=1 expected no response");
      end else begin
        e0 = q0.pop_front();
        chk("wrap_rd_data", 64'(rd_data0), 64'(e0.data));
        chk("wrap_rd_err", 64'(rd_err0), 64'(e0.err));
      end
    end
  end

  // Saturating bank response monitor.
  always @(negedge clk) begin
    if (rd_valid1 === 1'b1) begin
      if (q1.size() == 0) begin
        n_total++;
        $display("FAIL sat_unexpected_rsp: got rd_valid=1 expected no response");
      end else begin
        e1 = q1.pop_front();
        chk("sat_rd_data", 64'(rd_data1), 64'(e1.data));
        chk("sat_rd_err", 64'(rd_err1), 64'(e1.err));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [IW-1:0] idx, input logic snap,
                    input logic [CW-1:0] x0, input logic [CW-1:0] x1,
                    input logic err);
    exp_t a, b;
    a.data = x0; a.err = err;
    b.data = x1; b.err = err;
    q0.push_back(a);
    q1.push_back(b);
    rd_req  = 1'b1;
    rd_idx  = idx;
    rd_snap = snap;
    tick();
    rd_req  = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) tick();
    chk("rst_valid0", 64'(rd_valid0), 64'(1'b0));
    chk("rst_data0", 64'(rd_data0), 64'(8'h00));
    chk("rst_err0", 64'(rd_err0), 64'(1'b0));
    chk("rst_ovf0", 64'(ovf0), 64'(5'b00000));
    chk("rst_frozen0", 64'(frozen0), 64'(1'b0));
    chk("rst_valid1", 64'(rd_valid1), 64'(1'b0));
    chk("rst_ovf1", 64'(ovf1), 64'(5'b00000));
    chk("rst_frozen1", 64'(frozen1), 64'(1'b0));
    rst = 1'b1;
    tick();

    // Overflow: 300 counted cycles on channel EV_INST
    enable = 1'b1;
    event_vec = 4'b0001 << EV_INST;
    repeat (300) tick();
    enable = 1'b0;
    event_vec = '0;
    rd(3'd0, 1'b0, 8'h2C, 8'hFF, 1'b0);
    rd(3'd4, 1'b0, 8'h2C, 8'hFF, 1'b0);
    rd(3'd1, 1'b0, 8'h00, 8'h00, 1'b0);
    chk("ovf_wrap", 64'(ovf0), 64'(5'b10001));
    chk("ovf_sat", 64'(ovf1), 64'(5'b10001));
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("ovf_clr0", 64'(ovf0), 64'(5'b00000));
    chk("ovf_clr1", 64'(ovf1), 64'(5'b00000));

    // Halt and snapshot: 10 event cycles, halt on the 10th
    enable = 1'b1;
    event_vec = 4'b0110;
    repeat (9) tick();
    halt = 1'b1;
    tick();
    chk("frozen_after_halt0", 64'(frozen0), 64'(1'b1));
    chk("frozen_after_halt1", 64'(frozen1), 64'(1'b1));
    repeat (5) tick();
    chk("frozen_held", 64'(frozen0), 64'(1'b1));
    rd(3'd1, 1'b1, 8'd10, 8'd10, 1'b0);
    rd(3'd2, 1'b1, 8'd10, 8'd10, 1'b0);
    rd(3'd4, 1'b1, 8'd10, 8'd10, 1'b0);
    rd(3'd1, 1'b0, 8'd10, 8'd10, 1'b0);
    rd(3'd0, 1'b0, 8'd0, 8'd0, 1'b0);

    // Clear from FROZEN, events in the clear cycle discarded
    halt = 1'b0;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    enable = 1'b0;
    event_vec = '0;
    chk("frozen_after_clr", 64'(frozen0), 64'(1'b0));
    chk("ovf_after_clr", 64'(ovf0), 64'(5'b00000));
    rd(3'd1, 1'b0, 8'd0, 8'd0, 1'b0);
    rd(3'd1, 1'b1, 8'd10, 8'd10, 1'b0);

    // Halt and clear together: clear wins, no snapshot
    enable = 1'b1;
    event_vec = 4'b0110;
    repeat (3) tick();
    rd(3'd1, 1'b0, 8'd3, 8'd3, 1'b0);
    halt = 1'b1;
    clear = 1'b1;
    tick();
    halt = 1'b0;
    clear = 1'b0;
    enable = 1'b0;
    event_vec = '0;
    chk("halt_clr_state", 64'(frozen0), 64'(1'b0));
    rd(3'd1, 1'b0, 8'd0, 8'd0, 1'b0);
    rd(3'd1, 1'b1, 8'd10, 8'd10, 1'b0);
    rd(3'd4, 1'b1, 8'd10, 8'd10, 1'b0);

    // Read timing: pre-increment value, back-to-back reads
    enable = 1'b1;
    event_vec = 4'b0001;
    repeat (5) tick();
    rd(3'd0, 1'b0, 8'd5, 8'd5, 1'b0);
    rd(3'd0, 1'b0, 8'd6, 8'd6, 1'b0);
    enable = 1'b0;
    event_vec = '0;

    // Out-of-range indices, then a good read of the cycle counter
    rd(3'd7, 1'b0, 8'd0, 8'd0, 1'b1);
    rd(3'd5, 1'b1, 8'd0, 8'd0, 1'b1);
    rd(3'd4, 1'b0, 8'd7, 8'd7, 1'b0);
    tick();
    chk("data_hold", 64'(rd_data0), 64'(8'd7));
    chk("valid_one_cycle", 64'(rd_valid0), 64'(1'b0));

    // Reset mid-operation with overflow flags set and a response in flight
    enable = 1'b1;
    event_vec = 4'b1111;
    repeat (260) tick();
    chk("ovf_all_set", 64'(ovf0), 64'(5'b11111));
    rd_req = 1'b1;
    rd_idx = 3'd0;
    rd_snap = 1'b0;
    @(posedge clk);
    #1;
    rd_req = 1'b0;
    rst = 1'b0;
    #1;
    chk("midrst_valid0", 64'(rd_valid0), 64'(1'b0));
    chk("midrst_data0", 64'(rd_data0), 64'(8'h00));
    chk("midrst_ovf0", 64'(ovf0), 64'(5'b00000));
    chk("midrst_ovf1", 64'(ovf1), 64'(5'b00000));
    chk("midrst_valid1", 64'(rd_valid1), 64'(1'b0));
    enable = 1'b0;
    event_vec = '0;
    tick();
    rst = 1'b1;
    tick();
    rd(3'd0, 1'b0, 8'd0, 8'd0, 1'b0);
    rd(3'd4, 1'b0, 8'd0, 8'd0, 1'b0);
    rd(3'd1, 1'b1, 8'd0, 8'd0, 1'b0);

    repeat (3) tick();
    chk("wrap_queue_drained", 64'(q0.size()), 64'(0));
    chk("sat_queue_drained", 64'(q1.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
